// File: rtl/blink_sequencer.sv
// Status-LED blink sequencer: five segments ON/OFF/ON/OFF/ON paced by a tick prescaler,
// launched by a one-shot start, cancellable by abort, with a one-cycle done pulse.
module blink_sequencer #(
   parameter int TICK_DIV = 50_000_000,
   parameter int ON_LEN   = 6,
   parameter int OFF_LEN  = 4,
   parameter int LAST_LEN = 7
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       abort,
   output logic       out,
   output logic       busy,
   output logic       done,
   output logic [2:0] seg_idx,
   output logic       tick
);

   localparam int NUM_SEG = 5;
   localparam int PRESC_W = $clog2(TICK_DIV);
   localparam int MAX_LEN = (ON_LEN > OFF_LEN)
                            ? ((ON_LEN > LAST_LEN) ? ON_LEN : LAST_LEN)
                            : ((OFF_LEN > LAST_LEN) ? OFF_LEN : LAST_LEN);
   localparam int CNT_W = $clog2(MAX_LEN) + 1;

   localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
   localparam logic [PRESC_W-1:0] PRESC_PEN  = PRESC_W'(TICK_DIV - 2);
   localparam logic [2:0]         SEG_FINAL  = 3'(NUM_SEG - 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t             state_reg;
   logic [PRESC_W-1:0] presc_reg;
   logic [CNT_W-1:0]   seg_cnt_reg;
   logic [2:0]         seg_idx_reg;
   logic               out_reg;
   logic               busy_reg;
   logic               done_reg;
   logic               tick_reg;

   // Terminal count per segment; entries past the last segment are never reached.
   logic [CNT_W-1:0] seg_last_cnt [8];

   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_seg_len
         localparam int LEN = (gi == NUM_SEG - 1) ? LAST_LEN :
                              (gi >= NUM_SEG)     ? 1        :
                              (gi % 2 == 0)       ? ON_LEN   : OFF_LEN;
         assign seg_last_cnt[gi] = CNT_W'(LEN - 1);
      end
   endgenerate

   logic presc_wrap;
   logic presc_pen;
   logic seg_end;
   logic final_seg;

   assign presc_wrap = (presc_reg == PRESC_LAST);
   assign presc_pen  = (presc_reg == PRESC_PEN);
   assign seg_end    = (seg_cnt_reg == seg_last_cnt[seg_idx_reg]);
   assign final_seg  = (seg_idx_reg == SEG_FINAL);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg   <= IDLE;
         presc_reg   <= '0;
         seg_cnt_reg <= '0;
         seg_idx_reg <= '0;
         out_reg     <= 1'b0;
         busy_reg    <= 1'b0;
         done_reg    <= 1'b0;
         tick_reg    <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               done_reg <= 1'b0;
               if (start && !abort) begin
                  state_reg   <= RUN;
                  presc_reg   <= '0;
                  seg_cnt_reg <= '0;
                  seg_idx_reg <= '0;
                  out_reg     <= 1'b1;
                  busy_reg    <= 1'b1;
                  tick_reg    <= 1'b0;
               end
            end

            RUN: begin
               if (abort) begin
                  state_reg   <= IDLE;
                  presc_reg   <= '0;
                  seg_cnt_reg <= '0;
                  seg_idx_reg <= '0;
                  out_reg     <= 1'b0;
                  busy_reg    <= 1'b0;
                  tick_reg    <= 1'b0;
               end else if (presc_wrap && seg_end && final_seg) begin
                  state_reg   <= DONE;
                  presc_reg   <= '0;
                  seg_cnt_reg <= '0;
                  seg_idx_reg <= '0;
                  out_reg     <= 1'b0;
                  busy_reg    <= 1'b0;
                  done_reg    <= 1'b1;
                  tick_reg    <= 1'b0;
               end else begin
                  // tick is registered, so it is raised one cycle ahead of the wrap value.
                  presc_reg <= presc_wrap ? '0 : presc_reg + 1'b1;
                  tick_reg  <= !presc_wrap && presc_pen;
                  if (presc_wrap) begin
                     if (seg_end) begin
                        seg_cnt_reg <= '0;
                        seg_idx_reg <= seg_idx_reg + 3'd1;
                        // Next segment is even (LED on) exactly when the current one is odd.
                        out_reg     <= seg_idx_reg[0];
                     end else begin
                        seg_cnt_reg <= seg_cnt_reg + 1'b1;
                     end
                  end
               end
            end

            DONE: begin
               state_reg <= IDLE;
               done_reg  <= 1'b0;
            end

            default: begin
               state_reg   <= IDLE;
               presc_reg   <= '0;
               seg_cnt_reg <= '0;
               seg_idx_reg <= '0;
               out_reg     <= 1'b0;
               busy_reg    <= 1'b0;
               done_reg    <= 1'b0;
               tick_reg    <= 1'b0;
            end
         endcase
      end
   end

   assign out     = out_reg;
   assign busy    = busy_reg;
   assign done    = done_reg;
   assign seg_idx = seg_idx_reg;
   assign tick    = tick_reg;

endmodule

// File: tb/tb_blink_sequencer.sv
// Bench for blink_sequencer: a TICK_DIV=4 default-length instance checked against a
// segment-arithmetic model, and a TICK_DIV=2 unit-length instance checked from a vector table.
module tb_blink_sequencer;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start_a = 1'b0, abort_a = 1'b0;
   logic       start_b = 1'b0, abort_b = 1'b0;
   logic       out_a, busy_a, done_a, tick_a;
   logic       out_b, busy_b, done_b, tick_b;
   logic [2:0] seg_a, seg_b;
   logic [6:0] a_vec, b_vec;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   blink_sequencer #(.TICK_DIV(4), .ON_LEN(6), .OFF_LEN(4), .LAST_LEN(7)) dut_a (
      .clk(clk), .reset(reset), .start(start_a), .abort(abort_a),
      .out(out_a), .busy(busy_a), .done(done_a), .seg_idx(seg_a), .tick(tick_a)
   );

   blink_sequencer #(.TICK_DIV(2), .ON_LEN(1), .OFF_LEN(1), .LAST_LEN(1)) dut_b (
      .clk(clk), .reset(reset), .start(start_b), .abort(abort_b),
      .out(out_b), .busy(busy_b), .done(done_b), .seg_idx(seg_b), .tick(tick_b)
   );

   assign a_vec = {out_a, busy_a, done_a, seg_a, tick_a};
   assign b_vec = {out_b, busy_b, done_b, seg_b, tick_b};

   function automatic logic [6:0] mk(input logic o, input logic b, input logic d,
                                     input logic [2:0] s, input logic t);
      return {o, b, d, s, t};
   endfunction

   // Model of instance A: mode plus elapsed cycles within the run.
   localparam int D_A     = 4;
   localparam int TOTAL_A = (6 + 4 + 6 + 4 + 7) * D_A;
   int len_a [5] = '{6, 4, 6, 4, 7};
   int mdl_st  = 0;  // 0 idle, 1 run, 2 done
   int mdl_off = 0;

   function automatic logic [6:0] mdl_vec();
      int acc;
      int seg;
      if (mdl_st == 0) return 7'd0;
      if (mdl_st == 2) return mk(1'b0, 1'b0, 1'b1, 3'd0, 1'b0);
      acc = 0;
      seg = 0;
      for (int k = 0; k < 5; k++) begin
         acc += len_a[k] * D_A;
         if (mdl_off >= acc) seg = k + 1;
      end
      return mk(seg % 2 == 0, 1'b1, 1'b0, 3'(seg), (mdl_off % D_A) == D_A - 1);
   endfunction

   task automatic mdl_update(input logic s, input logic a);
      case (mdl_st)
         0: if (s && !a) begin mdl_st = 1; mdl_off = 0; end
         1: begin
            if (a) mdl_st = 0;
            else if (mdl_off == TOTAL_A - 1) mdl_st = 2;
            else mdl_off++;
         end
         default: mdl_st = 0;
      endcase
   endtask

   task automatic check_vec(input string name, input logic [6:0] act, input logic [6:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s t=%0t actual={out,busy,done,seg,tick}=%b required=%b",
                  name, $time, act, exp);
      end
   endtask

   // Called at posedge+1; drives inputs for the coming edge, then checks A against the model.
   task automatic step_a(input logic s, input logic a);
      start_a = s;
      abort_a = a;
      @(posedge clk);
      mdl_update(s, a);
      #1;
      check_vec("a_model", a_vec, mdl_vec());
   endtask

   typedef struct {
      logic       start;
      logic       abort;
      logic [6:0] exp;
   } vec_t;

   vec_t tbl [19];

   initial begin
      tbl[0]  = '{1'b1, 1'b0, mk(1, 1, 0, 3'd0, 0)};
      tbl[1]  = '{1'b0, 1'b0, mk(1, 1, 0, 3'd0, 1)};
      tbl[2]  = '{1'b0, 1'b0, mk(0, 1, 0, 3'd1, 0)};
      tbl[3]  = '{1'b0, 1'b0, mk(0, 1, 0, 3'd1, 1)};
      tbl[4]  = '{1'b0, 1'b0, mk(1, 1, 0, 3'd2, 0)};
      tbl[5]  = '{1'b0, 1'b0, mk(1, 1, 0, 3'd2, 1)};
      tbl[6]  = '{1'b0, 1'b0, mk(0, 1, 0, 3'd3, 0)};
      tbl[7]  = '{1'b0, 1'b0, mk(0, 1, 0, 3'd3, 1)};
      tbl[8]  = '{1'b0, 1'b0, mk(1, 1, 0, 3'd4, 0)};
      tbl[9]  = '{1'b0, 1'b0, mk(1, 1, 0, 3'd4, 1)};
      tbl[10] = '{1'b0, 1'b0, mk(0, 0, 1, 3'd0, 0)};
      tbl[11] = '{1'b0, 1'b0, 7'd0};
      tbl[12] = '{1'b1, 1'b1, 7'd0};
      tbl[13] = '{1'b1, 1'b0, mk(1, 1, 0, 3'd0, 0)};
      tbl[14] = '{1'b0, 1'b1, 7'd0};
      tbl[15] = '{1'b0, 1'b1, 7'd0};
      tbl[16] = '{1'b1, 1'b0, mk(1, 1, 0, 3'd0, 0)};
      tbl[17] = '{1'b1, 1'b0, mk(1, 1, 0, 3'd0, 1)};
      tbl[18] = '{1'b0, 1'b1, 7'd0};

      // Reset held: everything quiet.
      repeat (3) @(posedge clk);
      #1;
      check_vec("reset_a", a_vec, 7'd0);
      check_vec("reset_b", b_vec, 7'd0);
      reset = 1'b0;
      mdl_st = 0;
      $display("reset released t=%0t", $time);
      repeat (5) step_a(1'b0, 1'b0);

      // Asynchronous reset while idle.
      reset = 1'b1;
      #1;
      check_vec("async_reset_idle", a_vec, 7'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      mdl_st = 0;

      // Full run from a single start pulse.
      $display("seq full_run t=%0t", $time);
      step_a(1'b1, 1'b0);
      for (int k = 1; k <= 110; k++) begin
         step_a(1'b0, 1'b0);
         if (k == 23)  check_vec("seg0_last", a_vec, mk(1, 1, 0, 3'd0, 1));
         if (k == 24)  check_vec("seg1_first", a_vec, mk(0, 1, 0, 3'd1, 0));
         if (k == 80)  check_vec("seg4_first", a_vec, mk(1, 1, 0, 3'd4, 0));
         if (k == 108) check_vec("done_pulse", a_vec, mk(0, 0, 1, 3'd0, 0));
         if (k == 109) check_vec("after_done", a_vec, 7'd0);
      end

      // Abort mid-run, then restart.
      $display("seq abort_restart t=%0t", $time);
      step_a(1'b1, 1'b0);
      for (int k = 1; k <= 29; k++) step_a(1'b0, 1'b0);
      step_a(1'b0, 1'b1);
      check_vec("abort_idle", a_vec, 7'd0);
      repeat (4) step_a(1'b0, 1'b0);
      step_a(1'b1, 1'b0);
      check_vec("restart", a_vec, mk(1, 1, 0, 3'd0, 0));
      step_a(1'b0, 1'b1);

      // Start held high: DONE, one IDLE cycle, then a fresh run.
      $display("seq start_held t=%0t", $time);
      for (int k = 0; k <= 120; k++) begin
         step_a(1'b1, 1'b0);
         if (k == 108) check_vec("held_done", a_vec, mk(0, 0, 1, 3'd0, 0));
         if (k == 109) check_vec("held_idle", a_vec, 7'd0);
         if (k == 110) check_vec("held_rerun", a_vec, mk(1, 1, 0, 3'd0, 0));
      end
      step_a(1'b0, 1'b1);

      // Abort on the final tick beats completion; start pulses mid-run are ignored.
      $display("seq abort_final_tick t=%0t", $time);
      step_a(1'b1, 1'b0);
      for (int k = 1; k <= 107; k++) step_a(k >= 10 && k <= 20, 1'b0);
      check_vec("final_tick", a_vec, mk(1, 1, 0, 3'd4, 1));
      step_a(1'b0, 1'b1);
      check_vec("abort_no_done", a_vec, 7'd0);
      step_a(1'b0, 1'b0);
      check_vec("abort_stays_idle", a_vec, 7'd0);

      // Asynchronous reset mid-run.
      $display("seq reset_mid_run t=%0t", $time);
      step_a(1'b1, 1'b0);
      repeat (30) step_a(1'b0, 1'b0);
      reset = 1'b1;
      #1;
      check_vec("async_reset_run", a_vec, 7'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      mdl_st = 0;
      repeat (3) step_a(1'b0, 1'b0);

      // Table for the unit-length instance.
      for (int i = 0; i < 19; i++) begin
         start_b = tbl[i].start;
         abort_b = tbl[i].abort;
         @(posedge clk);
         #1;
         $display("vec %0d start=%b abort=%b out_vec=%b", i, tbl[i].start, tbl[i].abort, b_vec);
         check_vec("b_table", b_vec, tbl[i].exp);
      end
      start_b = 1'b0;
      abort_b = 1'b0;

      // Randomized traffic on instance A.
      for (int i = 0; i < 3000; i++) begin
         step_a($urandom_range(0, 7) == 0, $urandom_range(0, 255) == 0);
      end
      $display("random 3000 cycles done t=%0t", $time);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
